// File: rtl/ps2_keyboard_tx.sv
// Device-side PS/2 transmitter: a byte FIFO feeds an 11-bit odd-parity frame
// serialiser that honours host inhibit and resends an aborted byte.
module ps2_keyboard_tx #(
  parameter int HALF_PERIOD = 16,
  parameter int GAP_CYCLES  = 64,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  input  logic                          inhibit,
  output logic                          ps2_clk,
  output logic                          ps2_data,
  output logic                          busy,
  output logic                          frame_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam int PMAX = (HALF_PERIOD > GAP_CYCLES) ? HALF_PERIOD : GAP_CYCLES;
  localparam int PW   = $clog2(PMAX + 1);
  localparam logic [PW-1:0] HP_LAST  = PW'(HALF_PERIOD - 1);
  localparam logic [PW-1:0] GAP_LAST = PW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    GAP  = 2'd3
  } state_t;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  // Frame bit idx of {stop, parity, data[7:0], start}; out-of-range reads as idle.
  function automatic logic frame_bit(input logic [7:0] d, input logic [3:0] idx);
    logic [10:0] f;
    f = {1'b1, odd_parity(d), d, 1'b0};
    return (idx <= 4'd10) ? f[idx] : 1'b1;
  endfunction

  state_t          state_r;
  logic [PW-1:0]   phase_r;
  logic [3:0]      bit_idx_r;
  logic [7:0]      byte_r;
  logic            retry_r;
  logic            ps2_clk_r;
  logic            ps2_data_r;
  logic            frame_done_r;
  logic            busy_r;
  logic            tx_ready_r;
  logic [7:0]      mem_r [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [CW-1:0]   count_r;

  logic            push_s;
  logic            pop_s;
  logic            load_s;
  logic            fifo_empty_s;
  logic [CW-1:0]   count_next_s;

  // FIFO handshake, frame-load decision and next occupancy.
  always_comb begin
    push_s       = tx_valid && tx_ready_r;
    fifo_empty_s = (count_r == {CW{1'b0}});
    load_s       = (state_r == IDLE) && !inhibit && (retry_r || !fifo_empty_s);
    pop_s        = (state_r == IDLE) && !inhibit && !retry_r && !fifo_empty_s;
    count_next_s = count_r;
    if (push_s && !pop_s) begin
      count_next_s = count_r + CW'(1);
    end else if (pop_s && !push_s) begin
      count_next_s = count_r - CW'(1);
    end else begin
      count_next_s = count_r;
    end
  end

  // Byte FIFO storage, pointers and the registered ready/busy flags.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= {CW{1'b0}};
      tx_ready_r <= 1'b1;
      busy_r     <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= tx_data;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r    <= count_next_s;
      tx_ready_r <= (count_next_s != DEPTH_C);
      busy_r     <= (state_r != IDLE) || load_s || retry_r ||
                    (count_next_s != {CW{1'b0}});
    end
  end

  // Frame serialiser: phase timing, bit sequencing, abort and retry.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r      <= IDLE;
      phase_r      <= {PW{1'b0}};
      bit_idx_r    <= 4'd0;
      byte_r       <= 8'h00;
      retry_r      <= 1'b0;
      ps2_clk_r    <= 1'b1;
      ps2_data_r   <= 1'b1;
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          ps2_clk_r <= 1'b1;
          phase_r   <= {PW{1'b0}};
          bit_idx_r <= 4'd0;
          if (load_s) begin
            if (!retry_r) begin
              byte_r <= mem_r[rd_ptr_r];
            end
            ps2_data_r <= 1'b0;
            state_r    <= HIGH;
          end else begin
            ps2_data_r <= 1'b1;
          end
        end
        HIGH: begin
          if (inhibit && (bit_idx_r != 4'd10)) begin
            ps2_clk_r  <= 1'b1;
            ps2_data_r <= 1'b1;
            retry_r    <= 1'b1;
            phase_r    <= {PW{1'b0}};
            state_r    <= IDLE;
          end else if (phase_r == HP_LAST) begin
            ps2_clk_r <= 1'b0;
            phase_r   <= {PW{1'b0}};
            state_r   <= LOW;
          end else begin
            phase_r <= phase_r + PW'(1);
          end
        end
        LOW: begin
          if (inhibit && (bit_idx_r != 4'd10)) begin
            ps2_clk_r  <= 1'b1;
            ps2_data_r <= 1'b1;
            retry_r    <= 1'b1;
            phase_r    <= {PW{1'b0}};
            state_r    <= IDLE;
          end else if (phase_r == HP_LAST) begin
            ps2_clk_r <= 1'b1;
            phase_r   <= {PW{1'b0}};
            if (bit_idx_r == 4'd10) begin
              ps2_data_r   <= 1'b1;
              frame_done_r <= 1'b1;
              retry_r      <= 1'b0;
              state_r      <= GAP;
            end else begin
              bit_idx_r  <= bit_idx_r + 4'd1;
              ps2_data_r <= frame_bit(byte_r, bit_idx_r + 4'd1);
              state_r    <= HIGH;
            end
          end else begin
            phase_r <= phase_r + PW'(1);
          end
        end
        GAP: begin
          ps2_clk_r  <= 1'b1;
          ps2_data_r <= 1'b1;
          if (phase_r == GAP_LAST) begin
            phase_r <= {PW{1'b0}};
            state_r <= IDLE;
          end else begin
            phase_r <= phase_r + PW'(1);
          end
        end
        default: begin
          state_r    <= IDLE;
          phase_r    <= {PW{1'b0}};
          ps2_clk_r  <= 1'b1;
          ps2_data_r <= 1'b1;
        end
      endcase
    end
  end

  assign ps2_clk    = ps2_clk_r;
  assign ps2_data   = ps2_data_r;
  assign frame_done = frame_done_r;
  assign busy       = busy_r;
  assign tx_ready   = tx_ready_r;
  assign fifo_count = count_r;

endmodule

// File: doc/ps2_keyboard_tx.md
Name: ps2_keyboard_tx

Overview:
- Device-side PS/2 transmitter: emulates a keyboard by serialising scan-code bytes onto ps2_clk/ps2_data.
- Drives the board's PS/2 keyboard receiver in loopback and self-test benches. Upstream logic (key scanner, test sequencer) pushes bytes through a valid/ready FIFO.
- Generates 11-bit frames with odd parity, honours a host inhibit, and retransmits an aborted byte.

Parameters:
- HALF_PERIOD, 16: clk cycles per ps2_clk high phase and per low phase (≥2).
- GAP_CYCLES, 64: idle clk cycles (ps2_clk=1, ps2_data=1) after each stop bit (≥1).
- FIFO_DEPTH, 8: byte FIFO entries (power of 2, ≥2).

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- tx_data  in  8  scan-code byte to send
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  FIFO can accept (= !full)
- inhibit  in  1  host holding the bus; no new frame, abort current frame
- ps2_clk  out  1  PS/2 clock to receiver; idle 1
- ps2_data  out  1  PS/2 data to receiver; idle 1
- busy  out  1  state != IDLE or FIFO non-empty or retry pending
- frame_done  out  1  one-cycle pulse when a stop bit completes
- fifo_count  out  $clog2(FIFO_DEPTH)+1  bytes held in FIFO

Behaviour:
- Reset (async, resetn=0): ps2_clk=1, ps2_data=1, tx_ready=1, busy=0, frame_done=0, fifo_count=0. FIFO, shift register and retry flag are cleared. A frame in flight is dropped immediately.
- FIFO:
  - Push when tx_valid && tx_ready. Pop only in IDLE when not empty.
  - Push and pop in the same cycle keep the count unchanged.
  - A byte pushed into an empty FIFO is poppable the following cycle.
  - Full: tx_ready=0 and tx_valid is ignored, with no overflow or corruption.
- Frame: start 0, data[0..7] LSB first, parity = ~^data (odd), stop 1. That is 11 bits and 11 ps2_clk falling edges.
- All outputs are registered.
- FSM states IDLE, HIGH, LOW, GAP. A phase counter counts HALF_PERIOD or GAP_CYCLES.
  - IDLE: lines at 1.
    - If retry is set and inhibit=0: reload the held byte.
    - Else if the FIFO is non-empty and inhibit=0: pop into the shift register.
    - On either load: bit_idx=0, ps2_data=0 on the next cycle, go to HIGH.
  - HIGH: ps2_clk=1 for HALF_PERIOD cycles, then ps2_clk=0 and go to LOW.
    - Data is stable ≥HALF_PERIOD cycles before each falling edge.
  - LOW: ps2_clk=0 for HALF_PERIOD cycles, then ps2_clk=1.
    - If bit_idx==10: ps2_data=1, pulse frame_done, clear retry, go to GAP.
    - Else: bit_idx+1, present the next bit on the same cycle as the rising edge, go to HIGH.
  - GAP: lines at 1 for GAP_CYCLES, then IDLE. inhibit during GAP only delays the IDLE start.
- Timing: first ps2_clk falling edge occurs HALF_PERIOD+1 cycles after the pop cycle. Frame length is 22*HALF_PERIOD cycles plus GAP_CYCLES.
- Inhibit in HIGH/LOW before the 10th rising edge (bit_idx<10):
  - Next cycle: ps2_clk=1, ps2_data=1, set retry, keep the byte, go to IDLE.
  - No frame_done pulse; the FIFO is not popped again.
  - After inhibit drops, the same byte is resent in full.
- Inhibit in HIGH/LOW during the stop bit (bit_idx==10): the frame completes normally.
- Deassertion of inhibit and a push in the same cycle: retry has priority over the FIFO head.
- busy falls only after GAP completes with the FIFO empty and no retry pending.

Test Plan:
- Push 0x1C, HALF_PERIOD=16:
  - Sampling ps2_data at each ps2_clk fall gives 0,0,0,1,1,1,0,0,0,0,1 (parity 0).
  - frame_done pulses once; busy=0 after GAP.
- Push 0x00, then 0xF0:
  - Parity bits are 1 and 1.
  - Frames are separated by ≥GAP_CYCLES cycles with both lines high.
- Hold inhibit, push 9 bytes back-to-back:
  - tx_ready=0 after the 8th push; fifo_count=8; 9th held until ready.
  - Release inhibit: 8 frames in push order.
- Inhibit for 40 cycles after the 5th falling edge of byte 0x5A:
  - Lines go to 1 the next cycle; no frame_done.
  - After release, a complete 0x5A frame follows; fifo_count unchanged by the retry.
- resetn low mid-frame (bit 3):
  - Outputs go to idle asynchronously; fifo_count=0.
  - After release, no activity until a new push.
- Loopback into the PS/2 keyboard receiver, sequence 0x1C,0xF0,0x1C:
  - Receiver reports make code 0x1C, then the release; no parity errors.
